// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M/RV64M multiply/divide unit behind a start/busy/done handshake.
// One quotient or product bit is produced per CALC cycle; FIX applies the sign and selects the half.
module muldiv_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_REM    = 3'b110;

   localparam int              CW        = $clog2(XLEN);
   localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state, state_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic [2:0]      op, op_d;
   logic            neg, neg_d;
   logic [XLEN-1:0] mcand, mcand_d;   // multiplicand, or divisor magnitude
   logic [XLEN-1:0] acc, acc_d;       // product high half, or partial remainder
   logic [XLEN-1:0] lo, lo_d;         // multiplier / product low half, or dividend / quotient
   logic [XLEN-1:0] result_d;
   logic            done_d;

   // Operand decode at acceptance: signedness, magnitudes and the single-cycle special cases.
   logic            signed_a, signed_b, sign_a, sign_b;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] mag_a, mag_b;

   always_comb begin
      signed_a = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                 (funct3 == F_DIV)  || (funct3 == F_REM);
      signed_b = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
      sign_a   = signed_a && op_a[XLEN-1];
      sign_b   = signed_b && op_b[XLEN-1];
      mag_a    = sign_a ? -op_a : op_a;
      mag_b    = sign_b ? -op_b : op_b;
      div_zero = funct3[2] && (op_b == '0);
      div_ovf  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                 (op_a == MOST_NEG) && (op_b == '1);
   end

   // Per-iteration datapath plus the final sign correction.
   logic [XLEN-1:0]   addend;
   logic [XLEN:0]     mul_sum, rem_sh, diff;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   div_val, div_fix;

   always_comb begin
      addend   = lo[0] ? mcand : '0;
      mul_sum  = {1'b0, acc} + {1'b0, addend};
      // Partial remainder stays below the divisor, so bit XLEN of diff is a clean borrow flag.
      rem_sh   = {acc, lo[XLEN-1]};
      diff     = rem_sh - {1'b0, mcand};
      prod     = {acc, lo};
      prod_fix = neg ? -prod : prod;
      div_val  = op[1] ? acc : lo;
      div_fix  = neg ? -div_val : div_val;
   end

   // NOTE: every signal written below gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      op_d     = op;
      neg_d    = neg;
      mcand_d  = mcand;
      acc_d    = acc;
      lo_d     = lo;
      result_d = result;
      done_d   = 1'b0;

      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  op_d = funct3;
                  if (div_zero) begin
                     result_d = funct3[1] ? op_a : '1;
                     done_d   = 1'b1;
                  end else if (div_ovf) begin
                     result_d = funct3[1] ? '0 : op_a;
                     done_d   = 1'b1;
                  end else begin
                     state_d = CALC;
                     cnt_d   = '0;
                     neg_d   = (funct3[2] && funct3[1]) ? sign_a : (sign_a ^ sign_b);
                     mcand_d = funct3[2] ? mag_b : mag_a;
                     acc_d   = '0;
                     lo_d    = funct3[2] ? mag_a : mag_b;
                  end
               end
            end
            CALC: begin
               if (op[2]) begin
                  if (!diff[XLEN]) begin
                     acc_d = diff[XLEN-1:0];
                     lo_d  = {lo[XLEN-2:0], 1'b1};
                  end else begin
                     acc_d = rem_sh[XLEN-1:0];
                     lo_d  = {lo[XLEN-2:0], 1'b0};
                  end
               end else begin
                  acc_d = mul_sum[XLEN:1];
                  lo_d  = {mul_sum[0], lo[XLEN-1:1]};
               end
               cnt_d = cnt + 1'b1;
               if (cnt == LAST_ITER) state_d = FIX;
            end
            FIX: begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (op[2])             result_d = div_fix;
               else if (op == F_MUL)  result_d = prod_fix[XLEN-1:0];
               else                   result_d = prod_fix[2*XLEN-1:XLEN];
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         op     <= '0;
         neg    <= 1'b0;
         mcand  <= '0;
         acc    <= '0;
         lo     <= '0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         op     <= op_d;
         neg    <= neg_d;
         mcand  <= mcand_d;
         acc    <= acc_d;
         lo     <= lo_d;
         result <= result_d;
         done   <= done_d;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed RV32M cases, special cases, flush/reset and
// handshake scenarios, plus random operations checked against a plain-arithmetic model.
module tb_muldiv_iter;

   localparam int XLEN = 32;
   localparam int LAT  = XLEN + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            flush;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   int              n_checks = 0;
   int              n_fail   = 0;
   logic [31:0]     last_res;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   muldiv_iter #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .flush  (flush),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   function automatic logic is_special(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
      return f[2] && ((b == 32'd0) ||
             ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Reference: RISC-V M-extension semantics using 64-bit host arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, q;
      logic [63:0] p;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'b000:  begin p = sa * sb; return p[31:0]; end
         3'b001:  begin p = sa * sb; return p[63:32]; end
         3'b010:  begin p = sa * longint'({32'd0, b}); return p[63:32]; end
         3'b011:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'b100:  begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            q = sa / sb; return q[31:0];
         end
         3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110:  begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            q = sa % sb; return q[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Issues one operation and waits (bounded) for its done pulse; lat = -1 on timeout.
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_cnt,
                        output logic done_next);
      @(negedge clk);
      start = 1'b1; funct3 = f; op_a = a; op_b = b;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; busy_cnt = 0;
      while (done !== 1'b1 && lat < 4 * LAT) begin
         if (busy === 1'b1) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      if (done !== 1'b1) lat = -1;
      if (busy === 1'b1) busy_cnt++;
      res = result;
      @(posedge clk); #1;
      done_next = done;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
      #12;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++;
      if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
      @(negedge clk);
      rst = 1'b0;
      last_res = '0;
   endtask

   task automatic run_table(input string name, input vec_t tbl[8], input int n);
      logic [31:0] res;
      int          lat, bcnt, exp_lat, exp_b;
      logic        dn;
      for (int i = 0; i < n; i++) begin
         do_op(tbl[i].f, tbl[i].a, tbl[i].b, res, lat, bcnt, dn);
         exp_lat = is_special(tbl[i].f, tbl[i].a, tbl[i].b) ? 0 : LAT;
         exp_b   = is_special(tbl[i].f, tbl[i].a, tbl[i].b) ? 0 : LAT;
         n_checks++;
         if (res !== tbl[i].exp) begin
            n_fail++; $display("FAIL %s_result[%0d]: got %h expected %h", name, i, res, tbl[i].exp);
         end
         n_checks++;
         if (lat != exp_lat) begin
            n_fail++; $display("FAIL %s_latency[%0d]: got %0d expected %0d", name, i, lat, exp_lat);
         end
         n_checks++;
         if (bcnt != exp_b) begin
            n_fail++; $display("FAIL %s_busy_cycles[%0d]: got %0d expected %0d", name, i, bcnt, exp_b);
         end
         n_checks++;
         if (dn !== 1'b0) begin
            n_fail++; $display("FAIL %s_done_width[%0d]: got %b expected 0", name, i, dn);
         end
         last_res = tbl[i].exp;
      end
   endtask

   task automatic test_mul_div();
      vec_t tbl[8];
      tbl[0] = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      tbl[1] = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
      tbl[2] = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tbl[3] = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      tbl[4] = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
      tbl[5] = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
      tbl[6] = '{3'b101, 32'd100,        32'd7,         32'd14};
      tbl[7] = '{3'b111, 32'd100,        32'd7,         32'd2};
      run_table("muldiv", tbl, 8);
   endtask

   task automatic test_special();
      vec_t tbl[8];
      tbl[0] = '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF};
      tbl[1] = '{3'b111, 32'd5,          32'd0,         32'd5};
      tbl[2] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
      tbl[3] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
      tbl[4] = '{3'b100, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF};
      tbl[5] = '{3'b110, 32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF};
      tbl[6] = tbl[0];
      tbl[7] = tbl[0];
      run_table("special", tbl, 6);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic [31:0] a, b, res, exp;
      logic [2:0]  f;
      int          lat, bcnt, exp_lat;
      logic        dn;
      for (int i = 0; i < 60; i++) begin
         f = 3'($urandom_range(0, 7));
         a = rand_operand();
         b = rand_operand();
         exp = model(f, a, b);
         exp_lat = is_special(f, a, b) ? 0 : LAT;
         do_op(f, a, b, res, lat, bcnt, dn);
         n_checks++;
         if (res !== exp) begin
            n_fail++; $display("FAIL rand_result[%0d] f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, exp);
         end
         n_checks++;
         if (lat != exp_lat) begin
            n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, exp_lat);
         end
         n_checks++;
         if (bcnt != exp_lat) begin
            n_fail++; $display("FAIL rand_busy_cycles[%0d]: got %0d expected %0d", i, bcnt, exp_lat);
         end
         last_res = exp;
      end
   endtask

   // Flush during CALC (edge 10) and on the completing edge: no done, result held.
   task automatic test_flush();
      int   flush_edge[2];
      logic saw_done;
      flush_edge[0] = 10;
      flush_edge[1] = LAT;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         start = 1'b1; funct3 = (k == 0) ? 3'b100 : 3'b000; op_a = 32'd1000; op_b = 32'd7;
         @(posedge clk); #1;
         start = 1'b0;
         repeat (flush_edge[k] - 1) @(posedge clk);
         @(negedge clk);
         flush = 1'b1;
         @(posedge clk); #1;
         flush = 1'b0;
         n_checks++;
         if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy[%0d]: got %b expected 0", k, busy); end
         saw_done = done;
         repeat (2 * LAT) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
         end
         n_checks++;
         if (saw_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done[%0d]: got %b expected 0", k, saw_done); end
         n_checks++;
         if (result !== last_res) begin
            n_fail++; $display("FAIL flush_result_held[%0d]: got %h expected %h", k, result, last_res);
         end
      end
   endtask

   // start together with flush must not be accepted (special case and normal case).
   task automatic test_flush_start();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         start = 1'b1; flush = 1'b1;
         funct3 = (k == 0) ? 3'b101 : 3'b000; op_a = 32'd9; op_b = (k == 0) ? 32'd0 : 32'd3;
         @(posedge clk); #1;
         start = 1'b0; flush = 1'b0;
         n_checks++;
         if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy[%0d]: got %b expected 0", k, busy); end
         n_checks++;
         if (done !== 1'b0) begin n_fail++; $display("FAIL flush_start_done[%0d]: got %b expected 0", k, done); end
         n_checks++;
         if (result !== last_res) begin
            n_fail++; $display("FAIL flush_start_result[%0d]: got %h expected %h", k, result, last_res);
         end
      end
   endtask

   task automatic test_async_reset();
      logic saw_done;
      @(negedge clk);
      start = 1'b1; funct3 = 3'b011; op_a = 32'hFFFF_0000; op_b = 32'h0001_2345;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL areset_precond_busy: got %b expected 1", busy); end
      rst = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b expected 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL areset_done: got %b expected 0", done); end
      n_checks++;
      if (result !== '0) begin n_fail++; $display("FAIL areset_result: got %h expected 0", result); end
      @(negedge clk);
      rst = 1'b0;
      last_res = '0;
      saw_done = 1'b0;
      repeat (2 * LAT) begin
         @(posedge clk); #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done !== 1'b0) begin n_fail++; $display("FAIL areset_no_done: got %b expected 0", saw_done); end
   endtask

   // start held high: MUL 3x5 accepted, operands switched to 6x6 while busy, accepted in the done cycle.
   task automatic test_back_to_back();
      int          edges[$];
      logic [31:0] vals[$];
      @(negedge clk);
      start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
      @(posedge clk); #1;
      op_a = 32'd6; op_b = 32'd6;
      for (int e = 1; e <= 3 * LAT; e++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            edges.push_back(e);
            vals.push_back(result);
            if (edges.size() == 2) start = 1'b0;
         end
      end
      start = 1'b0;
      n_checks++;
      if (edges.size() != 2) begin
         n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", edges.size());
      end else begin
         n_checks++;
         if (edges[0] != LAT) begin n_fail++; $display("FAIL b2b_first_edge: got %0d expected %0d", edges[0], LAT); end
         n_checks++;
         if (edges[1] != 2 * LAT + 1) begin
            n_fail++; $display("FAIL b2b_second_edge: got %0d expected %0d", edges[1], 2 * LAT + 1);
         end
         n_checks++;
         if (vals[0] !== model(3'b000, 32'd3, 32'd5)) begin
            n_fail++; $display("FAIL b2b_first_result: got %h expected %h", vals[0], model(3'b000, 32'd3, 32'd5));
         end
         n_checks++;
         if (vals[1] !== model(3'b000, 32'd6, 32'd6)) begin
            n_fail++; $display("FAIL b2b_second_result: got %h expected %h", vals[1], model(3'b000, 32'd6, 32'd6));
         end
      end
      last_res = 32'd36;
   endtask

   // A start pulse while busy (a divide-by-zero that would finish instantly) must be ignored.
   task automatic test_busy_ignore();
      int          edges[$];
      logic [31:0] vals[$];
      @(negedge clk);
      start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      for (int e = 1; e <= LAT + 6; e++) begin
         if (e == 5) begin
            @(negedge clk);
            start = 1'b1; funct3 = 3'b101; op_a = 32'd99; op_b = 32'd0;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (done === 1'b1) begin
            edges.push_back(e);
            vals.push_back(result);
         end
      end
      n_checks++;
      if (edges.size() != 1) begin
         n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", edges.size());
      end else begin
         n_checks++;
         if (edges[0] != LAT) begin n_fail++; $display("FAIL ignore_done_edge: got %0d expected %0d", edges[0], LAT); end
         n_checks++;
         if (vals[0] !== 32'd15) begin n_fail++; $display("FAIL ignore_result: got %h expected %h", vals[0], 32'd15); end
      end
      last_res = 32'd15;
   endtask

   initial begin
      test_reset();
      test_mul_div();
      test_special();
      test_flush();
      test_flush_start();
      test_back_to_back();
      test_busy_ignore();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative RV32M/RV64M multiply/divide unit. It sits beside the single-cycle ALU and is selected when the decoder sees funct7 = 0000001 on an R-type instruction.
- Generalises the ALU operation set with parametrised width, signed/unsigned operand modes, and a multi-cycle start/busy/done handshake.
- The pipeline stalls on busy and captures result on done.

Parameters:
- XLEN, 32, operand/result width in bits (any value >= 4; 32 and 64 are supported).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only at an edge where busy = 0 and flush = 0
- flush  input  1  synchronous abort of any in-flight operation
- funct3  input  3  operation select, sampled with start
- op_a  input  XLEN  rs1 operand, sampled with start
- op_b  input  XLEN  rs2 operand, sampled with start
- busy  output  1  high while an accepted operation is in flight
- done  output  1  one-cycle pulse: result valid
- result  output  XLEN  registered result, held until the next done

Behaviour:
- Reset (async, rst = 1): state IDLE; busy = 0, done = 0, result = 0, iteration counter = 0, internal accumulators = 0. Reset mid-operation discards the operation with no done pulse.
- funct3 encoding:
  - 000 MUL: low XLEN bits of product
  - 001 MULH: high half, signed x signed
  - 010 MULHSU: high half, signed op_a x unsigned op_b
  - 011 MULHU: high half, unsigned x unsigned
  - 100 DIV: signed quotient
  - 101 DIVU: unsigned quotient
  - 110 REM: signed remainder
  - 111 REMU: unsigned remainder
- States: IDLE, CALC, FIX.
- Acceptance: the edge where start = 1, busy = 0, flush = 0 is edge 0. At that edge the unit latches funct3, the operand magnitudes and the result sign flags.
- Signed operands (per funct3) are converted to magnitude. Sign flags:
  - product sign = sign_a XOR sign_b
  - quotient sign = sign_a XOR sign_b
  - remainder sign = sign_a
- Special cases are resolved at edge 0 with no CALC:
  - Divide by zero (op_b = 0, funct3 = 1xx): DIV/DIVU give all-ones; REM/REMU give op_a.
  - Signed overflow (DIV/REM, op_a = 100..0, op_b = all-ones): DIV gives op_a; REM gives 0.
  - Effect: result loaded and done = 1 after edge 0; busy stays 0. Latency is 1 cycle.
- Normal path:
  - IDLE -> CALC at edge 0; busy = 1.
  - CALC runs exactly XLEN iterations (edges 1..XLEN), one bit per edge:
    - Multiply: radix-2 shift-add into a 2*XLEN product.
    - Divide: restoring shift-subtract, producing quotient and remainder magnitudes.
  - CALC -> FIX at edge XLEN.
  - At edge XLEN+1: FIX applies two's-complement sign correction, selects the low or high half, or quotient or remainder, loads result, sets done = 1 and busy = 0, and returns to IDLE.
  - Total latency is XLEN+1 edges from acceptance (33 for XLEN = 32).
- Widths: product held in 2*XLEN bits; divider remainder held in XLEN+1 bits; all arithmetic wraps modulo 2^width. MUL low half is identical for any signedness.
- done: high for exactly one cycle, i.e. the cycle after the completing edge, and cleared at the next edge.
- result: changes only at a completing edge; it is stable between completions and unaffected by flush.
- Back-to-back: start may be high during the done cycle (busy = 0). It is accepted at that edge, and done falls at the same edge.
- start while busy = 1: ignored, not queued; operands and funct3 changes are ignored.
- flush = 1 at any edge:
  - Takes priority over start and over completion.
  - Next state IDLE; busy = 0, done = 0; no done pulse for the aborted operation; result unchanged.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then MUL (funct3 = 000): op_a = 7, op_b = 0xFFFFFFFD, start at edge 0 -> busy = 1 for edges 1..32, done pulse after edge 33, result = 0xFFFFFFEB.
- MULH/MULHSU/MULHU (expected result high half):
  - MULH 0x80000000 x 0x80000000 -> 0x40000000
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE
- DIV/REM 0xFFFFFFF9 (-7) by 2 -> 0xFFFFFFFD and 0xFFFFFFFF; DIVU/REMU 100 by 7 -> 14 and 2; each completes at edge 33.
- Special cases:
  - DIVU 5 by 0 -> 0xFFFFFFFF
  - REMU 5 by 0 -> 5
  - DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000
  - REM 0x80000000 by 0xFFFFFFFF -> 0
  - Each gives done after edge 0 (1 cycle) and busy is never 1.
- Flush and reset:
  - Start DIV, flush at edge 10 -> busy = 0 after edge 10, no done pulse, result keeps its previous value.
  - Start with flush at the same edge -> not accepted.
  - Assert rst asynchronously mid-CALC -> busy = 0, done = 0, result = 0 immediately.
- Back-to-back: hold start high with MUL 3 x 5 then MUL 6 x 6 -> done pulses after edges 33 and 67, results 15 then 36.
  - Start pulsed while busy -> ignored, and the first result is unaffected.
